// File: rtl/sine.sv
// Integer-degree sine generator: 9-bit angle in, signed Q16.16 sin(angle) out.
// Quarter-wave table with quadrant folding, fixed three-cycle latency.
module sine (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start,
    input  logic [8:0]         value,
    output logic               done,
    output logic signed [31:0] amp_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        LOOK = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [8:0]           val_q, val_d;
    logic [6:0]           idx_q, idx_d;
    logic                 neg_q, neg_d;
    logic [16:0]          mag_q, mag_d;
    logic                 sgn_q, sgn_d;
    logic signed [31:0]   amp_q, amp_d;
    logic                 done_q, done_d;

    logic [8:0]           angle;
    logic [6:0]           fold_idx;
    logic                 fold_neg;

    // round(sin(k deg) * 65536) for k = 0..90
    function automatic logic [16:0] quarter_rom(input logic [6:0] k);
        case (k)
            7'd0:  quarter_rom = 17'd0;
            7'd1:  quarter_rom = 17'd1144;
            7'd2:  quarter_rom = 17'd2287;
            7'd3:  quarter_rom = 17'd3430;
            7'd4:  quarter_rom = 17'd4572;
            7'd5:  quarter_rom = 17'd5712;
            7'd6:  quarter_rom = 17'd6850;
            7'd7:  quarter_rom = 17'd7987;
            7'd8:  quarter_rom = 17'd9121;
            7'd9:  quarter_rom = 17'd10252;
            7'd10: quarter_rom = 17'd11380;
            7'd11: quarter_rom = 17'd12505;
            7'd12: quarter_rom = 17'd13626;
            7'd13: quarter_rom = 17'd14742;
            7'd14: quarter_rom = 17'd15855;
            7'd15: quarter_rom = 17'd16962;
            7'd16: quarter_rom = 17'd18064;
            7'd17: quarter_rom = 17'd19161;
            7'd18: quarter_rom = 17'd20252;
            7'd19: quarter_rom = 17'd21336;
            7'd20: quarter_rom = 17'd22415;
            7'd21: quarter_rom = 17'd23486;
            7'd22: quarter_rom = 17'd24550;
            7'd23: quarter_rom = 17'd25607;
            7'd24: quarter_rom = 17'd26656;
            7'd25: quarter_rom = 17'd27697;
            7'd26: quarter_rom = 17'd28729;
            7'd27: quarter_rom = 17'd29753;
            7'd28: quarter_rom = 17'd30767;
            7'd29: quarter_rom = 17'd31772;
            7'd30: quarter_rom = 17'd32768;
            7'd31: quarter_rom = 17'd33754;
            7'd32: quarter_rom = 17'd34729;
            7'd33: quarter_rom = 17'd35693;
            7'd34: quarter_rom = 17'd36647;
            7'd35: quarter_rom = 17'd37590;
            7'd36: quarter_rom = 17'd38521;
            7'd37: quarter_rom = 17'd39441;
            7'd38: quarter_rom = 17'd40348;
            7'd39: quarter_rom = 17'd41243;
            7'd40: quarter_rom = 17'd42126;
            7'd41: quarter_rom = 17'd42995;
            7'd42: quarter_rom = 17'd43852;
            7'd43: quarter_rom = 17'd44695;
            7'd44: quarter_rom = 17'd45525;
            7'd45: quarter_rom = 17'd46341;
            7'd46: quarter_rom = 17'd47143;
            7'd47: quarter_rom = 17'd47930;
            7'd48: quarter_rom = 17'd48703;
            7'd49: quarter_rom = 17'd49461;
            7'd50: quarter_rom = 17'd50203;
            7'd51: quarter_rom = 17'd50931;
            7'd52: quarter_rom = 17'd51643;
            7'd53: quarter_rom = 17'd52339;
            7'd54: quarter_rom = 17'd53020;
            7'd55: quarter_rom = 17'd53684;
            7'd56: quarter_rom = 17'd54332;
            7'd57: quarter_rom = 17'd54963;
            7'd58: quarter_rom = 17'd55578;
            7'd59: quarter_rom = 17'd56175;
            7'd60: quarter_rom = 17'd56756;
            7'd61: quarter_rom = 17'd57319;
            7'd62: quarter_rom = 17'd57865;
            7'd63: quarter_rom = 17'd58393;
            7'd64: quarter_rom = 17'd58903;
            7'd65: quarter_rom = 17'd59396;
            7'd66: quarter_rom = 17'd59870;
            7'd67: quarter_rom = 17'd60326;
            7'd68: quarter_rom = 17'd60764;
            7'd69: quarter_rom = 17'd61183;
            7'd70: quarter_rom = 17'd61584;
            7'd71: quarter_rom = 17'd61966;
            7'd72: quarter_rom = 17'd62328;
            7'd73: quarter_rom = 17'd62672;
            7'd74: quarter_rom = 17'd62997;
            7'd75: quarter_rom = 17'd63303;
            7'd76: quarter_rom = 17'd63589;
            7'd77: quarter_rom = 17'd63856;
            7'd78: quarter_rom = 17'd64104;
            7'd79: quarter_rom = 17'd64332;
            7'd80: quarter_rom = 17'd64540;
            7'd81: quarter_rom = 17'd64729;
            7'd82: quarter_rom = 17'd64898;
            7'd83: quarter_rom = 17'd65048;
            7'd84: quarter_rom = 17'd65177;
            7'd85: quarter_rom = 17'd65287;
            7'd86: quarter_rom = 17'd65376;
            7'd87: quarter_rom = 17'd65446;
            7'd88: quarter_rom = 17'd65496;
            7'd89: quarter_rom = 17'd65526;
            7'd90: quarter_rom = 17'd65536;
            default: quarter_rom = 17'd0;
        endcase
    endfunction

    // Magnitude is zero-extended first, so a zero entry stays zero after negation
    function automatic logic signed [31:0] apply_sign(input logic [16:0] mag,
                                                      input logic        neg);
        logic signed [31:0] ext;
        ext = signed'({15'd0, mag});
        return neg ? -ext : ext;
    endfunction

    // Inputs 360..511 encode value-512 degrees; adding 360 maps them to 208..359
    always_comb begin
        angle    = (val_q < 9'd360) ? val_q : (val_q - 9'd152);
        fold_idx = angle[6:0];
        fold_neg = 1'b0;
        if (angle <= 9'd90) begin
            fold_idx = angle[6:0];
        end else if (angle <= 9'd180) begin
            fold_idx = 7'(9'd180 - angle);
        end else if (angle <= 9'd270) begin
            fold_idx = 7'(angle - 9'd180);
            fold_neg = 1'b1;
        end else begin
            fold_idx = 7'(9'd360 - angle);
            fold_neg = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        idx_d   = idx_q;
        neg_d   = neg_q;
        mag_d   = mag_q;
        sgn_d   = sgn_q;
        amp_d   = amp_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    val_d   = value;
                    state_d = FOLD;
                end
            end
            FOLD: begin
                idx_d   = fold_idx;
                neg_d   = fold_neg;
                state_d = LOOK;
            end
            LOOK: begin
                mag_d   = quarter_rom(idx_q);
                sgn_d   = neg_q;
                state_d = OUT;
            end
            OUT: begin
                amp_d   = apply_sign(mag_q, sgn_q);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            val_q   <= 9'd0;
            idx_q   <= 7'd0;
            neg_q   <= 1'b0;
            mag_q   <= 17'd0;
            sgn_q   <= 1'b0;
            amp_q   <= 32'sd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            idx_q   <= idx_d;
            neg_q   <= neg_d;
            mag_q   <= mag_d;
            sgn_q   <= sgn_d;
            amp_q   <= amp_d;
            done_q  <= done_d;
        end
    end

    assign done    = done_q;
    assign amp_out = amp_q;

endmodule

// File: tb/tb_sine.sv
// Bench for sine: directed shots plus randomized streaming against a
// real-arithmetic sine model with an acceptance/latency schedule.
module tb_sine;

    logic               clk;
    logic               rst;
    logic               start;
    logic [8:0]         value;
    logic               done;
    logic signed [31:0] amp_out;

    int checks = 0;
    int errors = 0;

    int                 edge_cnt  = 0;
    int                 free_edge = 0;
    int                 due_edge  = -1;
    int                 pend      = 0;
    logic               done_exp  = 1'b0;
    logic signed [31:0] amp_exp   = 32'sd0;

    sine dut (
        .clk_in  (clk),
        .rst_in  (rst),
        .start   (start),
        .value   (value),
        .done    (done),
        .amp_out (amp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Codes 360..511 are the negative angle code-512; rounding is half away from zero
    function automatic int sin_ref(input int v);
        real deg, r;
        deg = (v < 360) ? real'(v) : real'(v - 512);
        r   = $sin(deg * 3.14159265358979323846 / 180.0) * 65536.0;
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    // One clock: advance the model on the inputs present at the edge, then compare
    task automatic step();
        @(posedge clk);
        if (rst) begin
            done_exp = 1'b0;
            amp_exp  = 32'sd0;
        end else begin
            edge_cnt++;
            done_exp = 1'b0;
            if (due_edge == edge_cnt) begin
                done_exp = 1'b1;
                amp_exp  = pend;
                due_edge = -1;
            end
            if (start && edge_cnt >= free_edge) begin
                pend      = sin_ref(int'(value));
                due_edge  = edge_cnt + 3;
                free_edge = edge_cnt + 4;
            end
        end
        #1;
        chk("done", {31'd0, done}, {31'd0, done_exp});
        chk("amp", amp_out, amp_exp);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        done_exp  = 1'b0;
        amp_exp   = 32'sd0;
        due_edge  = -1;
        free_edge = 0;
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_amp", amp_out, 32'sd0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic shot(input int v, input int expv, input bit chg);
        int lat;
        logic signed [31:0] res;
        start = 1'b0;
        repeat (5) step();
        start = 1'b1;
        value = 9'(v);
        step();
        start = 1'b0;
        if (chg) value = 9'd0;
        lat = -1;
        res = 32'sd0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (done && lat < 0) begin
                lat = i;
                res = amp_out;
            end
        end
        chk($sformatf("lat%0d", v), lat, 3);
        chk($sformatf("amp%0d", v), res, expv);
    endtask

    initial begin
        int sv[11];
        int se[11];
        logic signed [31:0] sr[3];
        int sp[3];
        int n;

        rst   = 1'b1;
        start = 1'b0;
        value = 9'd0;
        #1;
        chk("init_done", {31'd0, done}, 32'd0);
        chk("init_amp", amp_out, 32'sd0);
        step();
        step();
        rst = 1'b0;

        sv = '{0, 30, 45, 90, 150, 180, 210, 270, 330, 502, 360};
        se = '{0, 32768, 46341, 65536, 32768, 0, -32768, -65536, -32768, -11380, -30767};
        for (int i = 0; i < 11; i++) shot(sv[i], se[i], 1'b0);
        shot(90, 65536, 1'b1);

        // Abort a conversion in flight while amp_out holds a nonzero value
        shot(360, -30767, 1'b0);
        start = 1'b1;
        value = 9'd90;
        step();
        step();
        start = 1'b0;
        apply_reset();
        repeat (8) step();

        // Streaming with start held high
        repeat (5) step();
        start = 1'b1;
        value = 9'd30;
        step();
        value = 9'd210;
        sr = '{32'h0BAD0BAD, 32'h0BAD0BAD, 32'h0BAD0BAD};
        sp = '{-100, -100, -100};
        n  = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (done && n < 3) begin
                sr[n] = amp_out;
                sp[n] = i;
                n++;
            end
        end
        chk("stream_n", n, 3);
        chk("stream0", sr[0], 32768);
        chk("stream1", sr[1], -32768);
        chk("stream2", sr[2], -32768);
        chk("stream_gap", sp[1] - sp[0], 4);
        chk("stream_lat", sp[0], 3);

        // Reset release with start held: accept on the first edge after release
        start = 1'b1;
        value = 9'd45;
        apply_reset();
        repeat (6) step();

        for (int c = 0; c < 1500; c++) begin
            start = ($urandom_range(0, 9) < 7);
            value = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 149) == 0) apply_reset();
            else step();
        end
        start = 1'b0;
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sine.md
# sine

Fixed-latency integer-degree sine generator. It accepts an angle in whole degrees and returns sin(angle) as a signed Q16.16 value, using a quarter-wave lookup table with quadrant folding. It is the trig primitive of the orientation pipeline: the view-vector calculator instantiates two copies with `start` tied high and consumes `amp_out` on `done`.

## Interface
- No parameters. Table contents and output format are fixed.
- `clk_in` input 1: system clock (100 MHz domain).
- `rst_in` input 1: reset, asynchronous, active-high.
- `start` input 1: request a conversion. Sampled only in IDLE. May be held high permanently.
- `value` input 9: angle in degrees, unsigned. 0..359 is a direct angle. 360..511 is a wrapped negative angle (value − 512°).
- `done` output 1: registered one-cycle pulse; `amp_out` is valid from this cycle on.
- `amp_out` output 32 signed: sin(angle) in Q16.16, range −65536..+65536. Holds its value until the next result.

## Operation
- Four-state FSM: IDLE, FOLD, LOOK, OUT.
- IDLE: if `start`=1, capture `value` into an internal register and go to FOLD. Otherwise stay in IDLE.
- FOLD: normalize the captured value to angle a in 0..359.
  - If value < 360: a = value.
  - Else: a = value − 152 (equivalent to value − 512 + 360).
  - Compute the quadrant and the table index:
    - 0..90: idx = a, positive.
    - 91..180: idx = 180 − a, positive.
    - 181..270: idx = a − 180, negative.
    - 271..359: idx = 360 − a, negative.
  - Go to LOOK.
- LOOK: register T[idx] and the sign flag. Go to OUT.
- OUT: drive `amp_out` ← negative ? −T : T (32-bit two's complement), `done` ← 1, state ← IDLE.
- Table T[k], k = 0..90: round(sin(k°) × 65536). Stored as 17-bit unsigned, zero-extended to 32 bits.
  - Endpoints: T[0]=0, T[30]=32768, T[45]=46341, T[90]=65536.
  - A synthesizable case ROM or initialized array is acceptable.
- Zero is never negated to a nonzero value. sin(180)=0 and sin(360−ε) obey the folding above.
- Changes on `value` after capture do not affect the result in flight.
- The input is captured only when IDLE accepts `start`; `value` is ignored at all other times.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `done`=0, `amp_out`=0, internal registers cleared. Reset mid-conversion aborts it; no `done` is produced for it.
- `start` accepted at rising edge N:
  - `amp_out` and `done` update at edge N+3.
  - `done` is high for exactly one cycle, N+3 to N+4.
- The FSM is in IDLE from edge N+3. The earliest next acceptance is edge N+4.
- With `start` held high, `done` pulses every 4 cycles. Each result reflects `value` as sampled at that conversion's acceptance edge.
- `start` is ignored in FOLD, LOOK and OUT; there is no queueing.
- `done` is 0 in every cycle not produced by OUT.
- Release of `rst_in` with `start`=1: first acceptance at the first rising edge after release.

## Test plan
- Reset: assert `rst_in` mid-conversion → `done`=0 and `amp_out`=0 immediately; no stray `done` after release.
- Single shots with `start` pulsed one cycle:
  - value=0 → 0; 30 → 32768; 45 → 46341; 90 → 65536 (0x00010000).
  - `done` is exactly 3 edges after acceptance.
- Quadrant folding:
  - 150 → 32768; 180 → 0; 210 → −32768; 270 → −65536 (0xFFFF0000); 330 → −32768.
- Wrapped negative input: value=502 (−10°) → −11380; value=360 (−152°) → −30767.
- Streaming:
  - `start` tied 1; change `value` 30 → 210 between acceptances → `done` every 4 cycles, results 32768 then −32768.
  - `amp_out` holds between pulses.
- Input change after capture: accept value=90, switch to 0 the next cycle → result 65536.
